tdisplay_seq: RTL and testbench
===============================

Name: tdisplay_seq

Overview:
Sequential, parametrised successor to the combinational temperature display converter. Accepts a signed integer Celsius reading over a valid/ready handshake. Optionally converts the reading to Fahrenheit, then produces a sign flag, an NDIG-digit BCD magnitude and an overflow flag. It sits between the temperature sensor front-end and the seven-segment multiplexer, and uses shift-subtract division plus double-dabble instead of wide combinational dividers.

Parameters:
W, 13, width of signed two's-complement input tc (integer degrees C)
NDIG, 4, number of BCD output digits (1..6)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  tc/c_f valid
in_ready  output  1  block can accept a reading (high only in IDLE)
tc  input  W  signed Celsius reading
c_f  input  1  0 = display Celsius, 1 = display Fahrenheit
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts result
sign  output  1  1 = displayed value negative
ovf  output  1  |value| > 10^NDIG-1; digits saturated
digits  output  4*NDIG  BCD digits; [3:0] = ones, [7:4] = tens, and so on
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; when rst_n = 0 at a rising edge of clk, all state is cleared.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, sign = 0, ovf = 0, digits = 0.
- Reset mid-operation: any in-flight conversion is abandoned; the block returns to the reset values above.
- Internal magnitude width: M = W+4.
- Capture: on the edge where in_valid && in_ready, register tc and c_f. Later changes on tc or c_f do not affect the result.
- Arithmetic:
  - Celsius mode: V = tc.
  - Fahrenheit mode: V = 32 + trunc(9*tc/5), where trunc rounds toward zero. Compute q = floor(9*|tc|/5) on magnitudes, then apply the sign of tc before adding 32.
- Sign and zero: sign = (V < 0). A zero result always has sign = 0 (no negative zero).
- Overflow: if |V| > 10^NDIG-1, ovf = 1 and every digit = 9. Otherwise ovf = 0 and digits = BCD(|V|), leading digits zero.
- FSM:
  - IDLE: in_ready = 1. On handshake -> DIV.
  - DIV: exactly M cycles, restoring division of 9*|tc| by 5, one quotient bit per cycle. In Celsius mode the cycles still elapse and the quotient is forced to |tc|, so latency is mode-independent.
  - FIX: 1 cycle. Apply sign, add 32 (F mode only), take |V|, set sign.
  - BCD: exactly M cycles of double-dabble: add 3 to each nibble >= 5, then shift left one bit. Internal BCD width is sufficient for M bits.
  - DONE: 1 cycle. Compare against 10^NDIG-1, load sign/ovf/digits, assert out_valid. Stay in DONE until out_ready.
  - DONE exit: on out_valid && out_ready -> IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency: handshake at edge k gives out_valid high after edge k+2M+2 (k+36 for W=13).
- Output stability: sign, ovf and digits change only when entering DONE. They are held stable while out_valid && !out_ready, and retain their values after the output handshake until the next result.
- in_valid outside IDLE: ignored, with no side effects.
- Most negative input: tc = -2^(W-1) is legal. Its magnitude fits in M bits.

Test Plan:
- Reset/idle: hold rst_n = 0 for 2 cycles mid-conversion, then release -> out_valid = 0, in_ready = 1, digits = 0, busy = 0; the next conversion is correct.
- Celsius sweep (W=13, NDIG=4, c_f = 0): tc = -256, -156, -20, 0, 156, 255 -> (sign, digits) = (1,0256), (1,0156), (1,0020), (0,0000), (0,0156), (0,0255). Each result appears exactly 36 cycles after acceptance, ovf = 0.
- Fahrenheit sweep (c_f = 1): tc = -256, -156, -20, 0, 156, 255 -> (1,0428), (1,0248), (1,0004), (0,0032), (0,0312), (0,0491).
- F-mode zero and sign boundary: tc = -18 gives F = 0 -> sign 0, digits 0000. tc = -17 gives F = 2 (trunc of -30.6 = -30) -> sign 0, digits 0002.
- Overflow (NDIG=2): tc = 100, c_f = 0 -> ovf 1, digits 99, sign 0. tc = -99 -> ovf 0, sign 1, digits 99.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid and toggle tc, c_f and in_valid -> outputs stable, in_ready = 0. Raise out_ready -> one handshake, IDLE next cycle, in_ready = 1.

Source files
------------

// File: rtl/tdisplay_seq_if.sv
// Handshake bundle for the sequential temperature display converter:
// reading in (tc/c_f) and BCD result out, each with valid/ready.
interface tdisplay_seq_if #(
  parameter int W    = 13,
  parameter int NDIG = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    tc;
  logic            c_f;
  logic            out_valid;
  logic            out_ready;
  logic            sign;
  logic            ovf;
  logic [4*NDIG-1:0] digits;

  modport master (
    output in_valid, tc, c_f, out_ready,
    input  in_ready, out_valid, sign, ovf, digits
  );

  modport slave (
    input  in_valid, tc, c_f, out_ready,
    output in_ready, out_valid, sign, ovf, digits
  );
endinterface

// File: rtl/tdisplay_seq.sv
// Sequential Celsius/Fahrenheit to signed BCD converter: shift-subtract
// divide by 5, sign/offset fix-up, then double-dabble into NDIG digits.
module tdisplay_seq #(
  parameter int W    = 13,
  parameter int NDIG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tdisplay_seq_if.slave bus,
  output logic          busy
);
  localparam int M    = W + 4;
  localparam int BD   = ((M + 2) / 3 > NDIG) ? (M + 2) / 3 : NDIG;
  localparam int CW   = (M > 32) ? M : 32;
  localparam int CNTW = $clog2(M);
  localparam logic [CW-1:0]       LIMIT = CW'(10 ** NDIG - 1);
  localparam logic signed [M:0]   F_OFS = (M + 1)'(32);

  typedef enum logic [2:0] {IDLE, DIV, FIX, BCD, DONE} state_t;
  state_t state;

  logic            neg_r;
  logic            cf_r;
  logic            sgn_r;
  logic [M-1:0]    mag_r;
  logic [M-1:0]    dvd;
  logic [M-1:0]    quo;
  logic [M-1:0]    bin;
  logic [M-1:0]    absv;
  logic [2:0]      rem;
  logic [4*BD-1:0] bcd;
  logic [CNTW-1:0] cnt;

  logic signed [M-1:0] tc_ext;
  logic [M-1:0]        tc_mag;
  logic [3:0]          rem_sh;
  logic [2:0]          rem_nx;
  logic                q_bit;
  logic [M-1:0]        q_sel;
  logic signed [M:0]   v;
  logic signed [M:0]   v_neg;
  logic [M-1:0]        v_abs;
  logic [4*BD-1:0]     bcd_adj;
  logic                ovf_nx;

  always_comb begin
    tc_ext = {{4{bus.tc[W-1]}}, bus.tc};
    tc_mag = tc_ext[M-1] ? $unsigned(-tc_ext) : $unsigned(tc_ext);

    // Remainder stays below 5, so 3 bits hold it between steps.
    rem_sh = {rem, dvd[M-1]};
    q_bit  = (rem_sh >= 4'd5);
    rem_nx = q_bit ? 3'(rem_sh - 4'd5) : rem_sh[2:0];

    // Celsius mode ignores the quotient so latency is mode-independent.
    q_sel = cf_r ? quo : mag_r;
    v     = neg_r ? -$signed({1'b0, q_sel}) : $signed({1'b0, q_sel});
    if (cf_r) v = v + F_OFS;
    v_neg = -v;
    v_abs = v[M] ? v_neg[M-1:0] : v[M-1:0];

    bcd_adj = bcd;
    for (int unsigned i = 0; i < BD; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    ovf_nx = (CW'(absv) > LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.sign      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.digits    <= '0;
      busy          <= 1'b0;
      neg_r         <= 1'b0;
      cf_r          <= 1'b0;
      sgn_r         <= 1'b0;
      mag_r         <= '0;
      dvd           <= '0;
      quo           <= '0;
      bin           <= '0;
      absv          <= '0;
      rem           <= '0;
      bcd           <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            neg_r        <= tc_ext[M-1];
            cf_r         <= bus.c_f;
            mag_r        <= tc_mag;
            dvd          <= (tc_mag << 3) + tc_mag;
            quo          <= '0;
            rem          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= {quo[M-2:0], q_bit};
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(M - 1)) state <= FIX;
        end
        FIX: begin
          sgn_r <= v[M];
          absv  <= v_abs;
          bin   <= v_abs;
          bcd   <= '0;
          cnt   <= '0;
          state <= BCD;
        end
        BCD: begin
          bcd <= (bcd_adj << 1) | (4*BD)'(bin[M-1]);
          bin <= bin << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(M - 1)) state <= DONE;
        end
        DONE: begin
          // First DONE cycle loads the result; later cycles wait for the consumer.
          if (!bus.out_valid) begin
            bus.sign      <= sgn_r;
            bus.ovf       <= ovf_nx;
            bus.digits    <= ovf_nx ? {NDIG{4'h9}} : bcd[4*NDIG-1:0];
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdisplay_seq.sv
// Randomised and directed bench for tdisplay_seq: a timeline/arithmetic model
// checked every cycle against two instances (NDIG=4 and NDIG=2).
module tb_tdisplay_seq;
  localparam int W   = 13;
  localparam int LAT = 2 * (W + 4) + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;

  tdisplay_seq_if #(.W(W), .NDIG(4)) a ();
  tdisplay_seq_if #(.W(W), .NDIG(2)) b ();

  assign b.in_valid  = a.in_valid;
  assign b.tc        = a.tc;
  assign b.c_f       = a.c_f;
  assign b.out_ready = a.out_ready;

  tdisplay_seq #(.W(W), .NDIG(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave), .busy(busy_a));
  tdisplay_seq #(.W(W), .NDIG(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave), .busy(busy_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // {sign, ovf, 6 BCD digits} of the displayed value
  function automatic logic [25:0] model(input int t, input bit f, input int nd);
    int v, mg, lim;
    logic s, o;
    logic [23:0] d;
    v   = f ? 32 + (9 * t) / 5 : t;
    s   = (v < 0);
    mg  = s ? -v : v;
    lim = 10 ** nd - 1;
    o   = (mg > lim);
    d   = '0;
    for (int i = 0; i < nd; i++) begin
      d[4*i +: 4] = o ? 4'd9 : 4'(mg % 10);
      mg = mg / 10;
    end
    return {s, o, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference timeline: accept in idle, result visible LAT edges later, held until out_ready.
  logic m_rdy = 1'b1, m_ov = 1'b0, m_busy = 1'b0;
  int   m_age = 0;
  logic [25:0] pa = '0, pb = '0, oa = '0, ob = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rdy <= 1'b1; m_ov <= 1'b0; m_busy <= 1'b0; m_age <= 0;
      oa <= '0; ob <= '0;
    end else if (m_rdy) begin
      if (a.in_valid) begin
        m_rdy <= 1'b0; m_busy <= 1'b1; m_age <= 0;
        pa <= model($signed(a.tc), a.c_f, 4);
        pb <= model($signed(a.tc), a.c_f, 2);
      end
    end else if (!m_ov) begin
      if (m_age == LAT - 1) begin
        m_ov <= 1'b1; oa <= pa; ob <= pb;
      end
      m_age <= m_age + 1;
    end else if (a.out_ready) begin
      m_ov <= 1'b0; m_busy <= 1'b0; m_rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycA", {a.in_ready, a.out_valid, busy_a, a.sign, a.ovf, a.digits},
                  {m_rdy, m_ov, m_busy, oa[25], oa[24], oa[15:0]});
      chk("cycB", {b.in_ready, b.out_valid, busy_b, b.sign, b.ovf, b.digits},
                  {m_rdy, m_ov, m_busy, ob[25], ob[24], ob[7:0]});
    end
  end

  task automatic convert(input int t, input bit f, input int bp);
    int n;
    int lat;
    n = 0;
    while (!a.in_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_wait", {31'd0, a.in_ready}, 32'd1);
    a.in_valid = 1'b1; a.tc = W'(t); a.c_f = f;
    @(negedge clk);
    a.in_valid = 1'b0; a.tc = W'($urandom); a.c_f = 1'($urandom);
    lat = 0;
    while (!a.out_valid && lat < LAT + 20) begin @(negedge clk); lat++; end
    chk("latency", lat, LAT);
    for (int i = 0; i < bp; i++) begin
      a.in_valid = 1'($urandom); a.tc = W'($urandom); a.c_f = 1'($urandom);
      @(negedge clk);
    end
    a.in_valid = 1'b0; a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
  endtask

  int          sw_tc [6] = '{-256, -156, -20, 0, 156, 255};
  logic [17:0] c_exp [6] = '{18'h20256, 18'h20156, 18'h20020, 18'h00000, 18'h00156, 18'h00255};
  logic [17:0] f_exp [6] = '{18'h20428, 18'h20248, 18'h20004, 18'h00032, 18'h00312, 18'h00491};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a.in_valid = 1'b0; a.tc = '0; a.c_f = 1'b0; a.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset", {a.in_ready, a.out_valid, busy_a, a.sign, a.ovf, a.digits}, {3'b100, 18'h0});
    rst_n = 1'b1;
    @(negedge clk);

    chk("pin_m17", model(-17, 1, 4), 26'h0000002);
    chk("pin_m18", model(-18, 1, 4), 26'h0000000);
    chk("pin_ovf", model(100, 0, 2), 26'h1000099);

    for (int i = 0; i < 6; i++) begin
      convert(sw_tc[i], 1'b0, 1);
      chk("c_sweep", {a.sign, a.ovf, a.digits}, c_exp[i]);
    end
    for (int i = 0; i < 6; i++) begin
      convert(sw_tc[i], 1'b1, 0);
      chk("f_sweep", {a.sign, a.ovf, a.digits}, f_exp[i]);
    end

    convert(-18, 1'b1, 0);
    chk("f_zero", {a.sign, a.ovf, a.digits}, 18'h00000);
    convert(-17, 1'b1, 0);
    chk("f_m17", {a.sign, a.ovf, a.digits}, 18'h00002);
    convert(-4096, 1'b1, 2);
    chk("f_min", {a.sign, a.ovf, a.digits}, 18'h27340);

    convert(100, 1'b0, 0);
    chk("ovf2", {b.sign, b.ovf, b.digits}, 10'h199);
    convert(-99, 1'b0, 0);
    chk("edge2", {b.sign, b.ovf, b.digits}, 10'h299);

    convert(77, 1'b0, 10);
    chk("backpressure", {a.sign, a.ovf, a.digits, a.in_ready}, {18'h00077, 1'b1});

    // Abandon a conversion part-way through with a two-cycle reset.
    a.in_valid = 1'b1; a.tc = W'(123); a.c_f = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset", {a.in_ready, a.out_valid, busy_a, a.digits}, {3'b100, 16'h0});
    rst_n = 1'b1;
    @(negedge clk);
    convert(123, 1'b1, 1);
    chk("post_reset", {a.sign, a.ovf, a.digits}, 18'h00253);

    for (int i = 0; i < 40; i++) begin
      int t;
      t = (i == 0) ? -4096 : (i == 1) ? 4095 : int'($urandom_range(0, 8191)) - 4096;
      convert(t, 1'($urandom), int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
